// File: rtl/imem_loader_if.sv
// Host and fetch signals of the instruction store, grouped for the loader and its user.
interface imem_loader_if;
  logic        start;
  logic [7:0]  base_address;
  logic [8:0]  byte_count;
  logic        abort;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [8:0]  bytes_written;
  logic [31:0] read_address;
  logic [31:0] instruction;

  modport master (
    output start, base_address, byte_count, abort, in_byte, in_valid, read_address,
    input  in_ready, busy, done, bytes_written, instruction
  );

  modport slave (
    input  start, base_address, byte_count, abort, in_byte, in_valid, read_address,
    output in_ready, busy, done, bytes_written, instruction
  );
endinterface

// File: rtl/imem_loader.sv
// 256-byte big-endian instruction store: byte-stream loader on the host side,
// registered 32-bit word read on the fetch side.
module imem_loader #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_BITS = 8
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] ptr;
  logic [8:0]           remaining;
  logic [7:0]           mem [MEM_BYTES];

  logic [8:0]           eff_count;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] rd_a0, rd_a1, rd_a2, rd_a3;
  logic                 unused_read_address_bits;

  assign eff_count = (bus.byte_count > 9'(MEM_BYTES)) ? 9'(MEM_BYTES) : bus.byte_count;
  // Abort and reset both win over a concurrent handshake, so the byte is dropped.
  assign mem_we    = (state == LOAD) && bus.in_valid && !bus.abort && !rst;

  assign rd_a0 = bus.read_address[ADDR_BITS-1:0];
  assign rd_a1 = rd_a0 + ADDR_BITS'(1);
  assign rd_a2 = rd_a0 + ADDR_BITS'(2);
  assign rd_a3 = rd_a0 + ADDR_BITS'(3);
  assign unused_read_address_bits = ^bus.read_address[31:ADDR_BITS];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ptr               <= '0;
      remaining         <= '0;
      bus.in_ready      <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.bytes_written <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            ptr               <= bus.base_address;
            remaining         <= eff_count;
            bus.bytes_written <= '0;
            if (eff_count == 9'd0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state        <= LOAD;
              bus.busy     <= 1'b1;
              bus.in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.in_ready <= 1'b0;
          end else if (bus.in_valid) begin
            ptr               <= ptr + ADDR_BITS'(1);
            remaining         <= remaining - 9'd1;
            bus.bytes_written <= bus.bytes_written + 9'd1;
            if (remaining == 9'd1) begin
              state        <= DONE;
              bus.busy     <= 1'b0;
              bus.in_ready <= 1'b0;
              bus.done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.in_ready <= 1'b0;
          bus.done     <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the byte array has no reset branch; rst must leave loaded code intact,
  // and a reset-free array maps onto block RAM with zero power-up contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= bus.in_byte;
  end

  // Reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) bus.instruction <= '0;
    else     bus.instruction <= {mem[rd_a0], mem[rd_a1], mem[rd_a2], mem[rd_a3]};
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, backpressure, wrap, abort, zero count,
// start-while-busy, read-before-write and reset mid-load.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  imem_loader_if bus ();

  imem_loader dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] base, input logic [8:0] count);
    bus.base_address = base;
    bus.byte_count   = count;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.bytes_written !== 9'd0) begin errors++; $display("FAIL reset_bytes_written: got %0d expected 0", bus.bytes_written); end
    checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction: got %h expected 00000000", bus.instruction); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] word;
    int          rdy_cycles;
    word = 32'h014B4824;
    rdy_cycles = 0;
    start_load(8'd0, 9'd4);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = word[31-8*i -: 8];
      if (bus.in_ready === 1'b1) rdy_cycles++;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_early_done[%0d]: got %b expected 0", i, bus.done); end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (rdy_cycles != 4) begin errors++; $display("FAIL basic_ready_cycles: got %0d expected 4", rdy_cycles); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", bus.done); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done: got %b expected 0", bus.in_ready); end
    checks++; if (bus.bytes_written !== 9'd4) begin errors++; $display("FAIL basic_bytes_written: got %0d expected 4", bus.bytes_written); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
    bus.read_address = 32'd0;
    tick();
    checks++; if (bus.instruction !== 32'h014B4824) begin errors++; $display("FAIL basic_fetch: got %h expected 014b4824", bus.instruction); end
  endtask

  task automatic test_backpressure();
    logic [31:0] word;
    word = 32'hAABBCCDD;
    start_load(8'd8, 9'd4);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_byte  = (i % 2 == 0) ? word[31-8*(i/2) -: 8] : 8'hEE;
      tick();
      checks++; if (bus.done !== (i == 6)) begin errors++; $display("FAIL bp_done[%0d]: got %b expected %b", i, bus.done, (i == 6)); end
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.bytes_written !== 9'd4) begin errors++; $display("FAIL bp_bytes_written: got %0d expected 4", bus.bytes_written); end
    bus.read_address = 32'd8;
    tick();
    checks++; if (bus.instruction !== 32'hAABBCCDD) begin errors++; $display("FAIL bp_fetch: got %h expected aabbccdd", bus.instruction); end
  endtask

  task automatic test_wrap();
    logic [31:0] word;
    word = 32'h11223344;
    start_load(8'd254, 9'd4);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = word[31-8*i -: 8];
      tick();
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b expected 1", bus.done); end
    bus.read_address = 32'hFFFF_FFFE;
    tick();
    checks++; if (bus.instruction !== 32'h11223344) begin errors++; $display("FAIL wrap_fetch_254: got %h expected 11223344", bus.instruction); end
    bus.read_address = 32'd0;
    tick();
    checks++; if (bus.instruction !== 32'h33444824) begin errors++; $display("FAIL wrap_fetch_0: got %h expected 33444824", bus.instruction); end
  endtask

  task automatic test_abort();
    logic [31:0] word;
    word = 32'hA1A2A300;
    start_load(8'd16, 9'd8);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = word[31-8*i -: 8];
      tick();
    end
    bus.in_byte = 8'h77;
    bus.abort   = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    checks++; if (bus.bytes_written !== 9'd3) begin errors++; $display("FAIL abort_bytes_written: got %0d expected 3", bus.bytes_written); end
    bus.read_address = 32'd16;
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_no_done_later: got %b expected 0", bus.done); end
    checks++; if (bus.instruction !== 32'hA1A2A300) begin errors++; $display("FAIL abort_fetch: got %h expected a1a2a300", bus.instruction); end
  endtask

  task automatic test_zero_count();
    start_load(8'h60, 9'd0);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.bytes_written !== 9'd0) begin errors++; $display("FAIL zero_bytes_written: got %0d expected 0", bus.bytes_written); end
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h99;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", bus.done); end
    bus.read_address = 32'h60;
    tick();
    checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL zero_no_write: got %h expected 00000000", bus.instruction); end
  endtask

  task automatic test_busy_ignore();
    start_load(8'd40, 9'd3);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hC1;
    tick();
    bus.start        = 1'b1;
    bus.base_address = 8'd80;
    bus.byte_count   = 9'd9;
    bus.in_byte      = 8'hC2;
    tick();
    bus.start   = 1'b0;
    bus.in_byte = 8'hC3;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b expected 1", bus.done); end
    checks++; if (bus.bytes_written !== 9'd3) begin errors++; $display("FAIL ignore_bytes_written: got %0d expected 3", bus.bytes_written); end
    bus.read_address = 32'd40;
    tick();
    checks++; if (bus.instruction !== 32'hC1C2C300) begin errors++; $display("FAIL ignore_fetch_40: got %h expected c1c2c300", bus.instruction); end
    bus.read_address = 32'd80;
    tick();
    checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL ignore_fetch_80: got %h expected 00000000", bus.instruction); end
  endtask

  task automatic test_rbw_and_reset();
    start_load(8'd32, 9'd4);
    bus.read_address = 32'd32;
    bus.in_valid     = 1'b1;
    bus.in_byte      = 8'h5A;
    tick();
    checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL rbw_old: got %h expected 00000000", bus.instruction); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.instruction !== 32'h5A000000) begin errors++; $display("FAIL rbw_new: got %h expected 5a000000", bus.instruction); end
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h6B;
    tick();
    bus.in_byte = 8'hFF;
    rst = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.instruction !== 32'h0) begin errors++; $display("FAIL rst_instruction: got %h expected 00000000", bus.instruction); end
    checks++; if (bus.bytes_written !== 9'd0) begin errors++; $display("FAIL rst_bytes_written: got %0d expected 0", bus.bytes_written); end
    rst          = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.instruction !== 32'h5A6B0000) begin errors++; $display("FAIL rst_persist: got %h expected 5a6b0000", bus.instruction); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_stays_idle: got %b expected 0", bus.busy); end
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.base_address = '0;
    bus.byte_count   = '0;
    bus.abort        = 1'b0;
    bus.in_byte      = '0;
    bus.in_valid     = 1'b0;
    bus.read_address = '0;

    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_zero_count();
    test_busy_ignore();
    test_rbw_and_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
